// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
// spi_pkg: shared types for the generic SPI master.
// Edge type is taken from bit 0 of the SCLK edge counter.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } spi_state_e;

    localparam logic EDGE_LEAD  = 1'b0;
    localparam logic EDGE_TRAIL = 1'b1;

endpackage

// File: rtl/spi_master_gen_if.sv
`timescale 1ns/1ps
// spi_master_gen_if: control bus and pin bundle of the SPI master.
// master = the SPI master itself, slave = controller/pin side.
interface spi_master_gen_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);

    logic              start;
    logic              cpol;
    logic              cpha;
    logic [CNT_W-1:0]  n_words;
    logic [DATA_W-1:0] din;
    logic              miso;
    logic              sclk;
    logic              mosi;
    logic              cs_n;
    logic              busy;
    logic [DATA_W-1:0] dout;
    logic              word_done;

    modport master (
        input  start, cpol, cpha, n_words, din, miso,
        output sclk, mosi, cs_n, busy, dout, word_done
    );

    modport slave (
        output start, cpol, cpha, n_words, din, miso,
        input  sclk, mosi, cs_n, busy, dout, word_done
    );

endinterface

// File: rtl/spi_clk_tick.sv
`timescale 1ns/1ps
// spi_clk_tick: half-period divider for Pmod serial blocks.
// o_tick pulses on the last of every CLK_DIV enabled cycles.
module spi_clk_tick #(
    parameter int CLK_DIV = 750
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == CW'(CLK_DIV - 1));

    always_ff @(posedge CLK) begin
        if (RST || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_gen.sv
`timescale 1ns/1ps
// spi_master_gen: CPOL/CPHA-configurable SPI master with multi-word bursts.
// SCLK, MOSI and CS_N are registers updated on divider ticks of CLK.
module spi_master_gen
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 750,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 8
) (
    input logic              CLK,
    input logic              RST,
    spi_master_gen_if.master bus
);

    localparam int EW = $clog2(2 * DATA_W);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W - 1);

    spi_state_e r_state, w_next;

    logic              r_cpol, r_cpha;
    logic [CNT_W-1:0]  r_words_left;
    logic [EW-1:0]     r_edge_cnt;
    logic [DATA_W-1:0] r_tx, r_rx, r_dout;
    logic              r_sclk, r_mosi, r_cs_n, r_word_done;

    logic              w_tick, w_start, w_shift_tick;
    logic              w_last, w_more, w_sample, w_drive;
    logic              w_tx_head, w_din_head;
    logic [DATA_W-1:0] w_tx_shift, w_din_shift, w_rx_shift, w_rx_next;

    spi_clk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .CLK    (CLK),
        .RST    (RST),
        .i_en   (r_state != IDLE),
        .i_clr  (r_state == IDLE),
        .o_tick (w_tick)
    );

    // The head bit is the next one on the wire; the shift drops it.
    if (MSB_FIRST != 0) begin : g_msb
        assign w_tx_head   = r_tx[DATA_W-1];
        assign w_din_head  = bus.din[DATA_W-1];
        assign w_tx_shift  = {r_tx[DATA_W-2:0], 1'b0};
        assign w_din_shift = {bus.din[DATA_W-2:0], 1'b0};
        assign w_rx_shift  = {r_rx[DATA_W-2:0], bus.miso};
    end else begin : g_lsb
        assign w_tx_head   = r_tx[0];
        assign w_din_head  = bus.din[0];
        assign w_tx_shift  = {1'b0, r_tx[DATA_W-1:1]};
        assign w_din_shift = {1'b0, bus.din[DATA_W-1:1]};
        assign w_rx_shift  = {bus.miso, r_rx[DATA_W-1:1]};
    end

    assign w_start      = (r_state == IDLE) && bus.start && (bus.n_words != '0);
    assign w_shift_tick = (r_state == SHIFT) && w_tick;
    assign w_last       = (r_edge_cnt == LAST_EDGE);
    assign w_more       = (r_words_left > CNT_W'(1));
    assign w_sample     = w_shift_tick &&
                          (r_edge_cnt[0] == (r_cpha ? EDGE_TRAIL : EDGE_LEAD));
    assign w_drive      = w_shift_tick && !w_sample && !w_last;
    assign w_rx_next    = w_sample ? w_rx_shift : r_rx;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_start) w_next = SETUP;
            SETUP:   if (w_tick) w_next = SHIFT;
            SHIFT:   if (w_tick && w_last && !w_more) w_next = HOLD;
            HOLD:    if (w_tick) w_next = DONE;
            DONE:    if (w_tick) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cpol       <= 1'b0;
            r_cpha       <= 1'b0;
            r_words_left <= '0;
            r_edge_cnt   <= '0;
            r_tx         <= '0;
            r_rx         <= '0;
            r_dout       <= '0;
            r_sclk       <= 1'b0;
            r_mosi       <= 1'b0;
            r_cs_n       <= 1'b1;
            r_word_done  <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            r_cs_n      <= (w_next == IDLE) || (w_next == DONE);

            if (r_state == IDLE)
                r_sclk <= bus.cpol;
            else if (w_shift_tick)
                r_sclk <= ~r_sclk;
            else if (r_state == HOLD || r_state == DONE)
                r_sclk <= r_cpol;

            // In mode cpha=0 the first bit must be on MOSI before any edge.
            if (w_start) begin
                r_cpol       <= bus.cpol;
                r_cpha       <= bus.cpha;
                r_words_left <= bus.n_words;
                r_edge_cnt   <= '0;
                r_rx         <= '0;
                if (bus.cpha) begin
                    r_tx <= bus.din;
                end else begin
                    r_tx   <= w_din_shift;
                    r_mosi <= w_din_head;
                end
            end

            if (w_shift_tick) begin
                r_rx <= w_rx_next;
                if (w_drive) begin
                    r_mosi <= w_tx_head;
                    r_tx   <= w_tx_shift;
                end
                if (w_last) begin
                    r_dout       <= w_rx_next;
                    r_word_done  <= 1'b1;
                    r_words_left <= r_words_left - 1'b1;
                    r_edge_cnt   <= '0;
                    if (w_more && r_cpha) begin
                        r_tx <= bus.din;
                    end else if (w_more) begin
                        r_tx   <= w_din_shift;
                        r_mosi <= w_din_head;
                    end
                end else begin
                    r_edge_cnt <= r_edge_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.sclk      = r_sclk;
    assign bus.mosi      = r_mosi;
    assign bus.cs_n      = r_cs_n;
    assign bus.busy      = (r_state != IDLE);
    assign bus.dout      = r_dout;
    assign bus.word_done = r_word_done;

endmodule

// File: tb/tb_spi_master_gen.sv
`timescale 1ns/1ps
// tb_spi_master_gen: scoreboard bench for spi_master_gen, with a bit-level
// SPI slave model on the 8-bit MSB-first instance and loopback on both.
module tb_spi_master_gen;

    localparam int DIV = 2;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    spi_master_gen_if #(.DATA_W(8),  .CNT_W(8)) b0 ();
    spi_master_gen_if #(.DATA_W(12), .CNT_W(8)) b1 ();

    spi_master_gen #(.DATA_W(8), .CLK_DIV(DIV), .MSB_FIRST(1), .CNT_W(8)) u0 (
        .CLK (CLK),
        .RST (RST),
        .bus (b0)
    );

    spi_master_gen #(.DATA_W(12), .CLK_DIV(DIV), .MSB_FIRST(0), .CNT_W(8)) u1 (
        .CLK (CLK),
        .RST (RST),
        .bus (b1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic loop0    = 1'b1;
    logic slv_miso = 1'b0;
    assign b0.miso = loop0 ? b0.mosi : slv_miso;
    assign b1.miso = b1.mosi;

    // reference data: words the master sends, words the slave returns
    logic [7:0]  tx_w[$];
    logic [7:0]  sl_w[$];
    logic [7:0]  exp_q0[$];
    logic [11:0] exp_q1[$];

    // slave model / monitor state
    bit         slv_bits[$];
    logic       slv_cpol = 1'b0;
    logic       slv_cpha = 1'b0;
    logic [7:0] mosi_q0[$];
    logic [7:0] rxw0;
    int         bitcnt0;
    int busy0, cslow0, edges0, tog0, wd0;
    logic first0;
    logic prev_cs0 = 1'b1;
    logic prev_sclk0 = 1'b0;

    int   e1, wd1;
    logic first1;
    logic cpha1_m = 1'b0;
    logic prev_cs1 = 1'b1;
    logic prev_sclk1 = 1'b0;

    bit   rdone;
    int   rn;
    bit   rcp, rch, rlp;
    logic [11:0] rd12;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // SPI slave model and activity counters for instance 0
    always begin
        @(posedge CLK);
        #1;
        if (b0.busy) busy0++;
        if (!b0.cs_n) cslow0++;
        if (b0.sclk !== prev_sclk0) tog0++;
        if (prev_cs0 && !b0.cs_n) begin
            bitcnt0 = 0;
            rxw0 = '0;
            if (!slv_cpha && slv_bits.size() > 0) slv_miso = slv_bits.pop_front();
        end
        if (!b0.cs_n && b0.sclk !== prev_sclk0) begin
            edges0++;
            if (edges0 == 1) first0 = b0.sclk;
            if ((b0.sclk != slv_cpol) ^ slv_cpha) begin
                rxw0 = {rxw0[6:0], b0.mosi};
                bitcnt0++;
                if (bitcnt0 == 8) begin
                    mosi_q0.push_back(rxw0);
                    bitcnt0 = 0;
                end
            end else if (slv_bits.size() > 0) begin
                slv_miso = slv_bits.pop_front();
            end
        end
        prev_cs0 = b0.cs_n;
        prev_sclk0 = b0.sclk;
    end

    // first-data-bit capture for instance 1
    always begin
        @(posedge CLK);
        #1;
        if (prev_cs1 && !b1.cs_n) e1 = 0;
        if (!b1.cs_n && b1.sclk !== prev_sclk1) begin
            e1++;
            if (e1 == (cpha1_m ? 2 : 1)) first1 = b1.mosi;
        end
        prev_cs1 = b1.cs_n;
        prev_sclk1 = b1.sclk;
    end

    // scoreboard: pop expected word on every word_done
    always begin
        @(posedge CLK);
        #1;
        if (b0.word_done) begin
            wd0++;
            if (exp_q0.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wd_unexpected0: got dout %0h, expected no word_done", b0.dout);
            end else begin
                chk("dout0", 32'(b0.dout), 32'(exp_q0.pop_front()));
            end
        end
        if (b1.word_done) begin
            wd1++;
            if (exp_q1.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wd_unexpected1: got dout %0h, expected no word_done", b1.dout);
            end else begin
                chk("dout1", 32'(b1.dout), 32'(exp_q1.pop_front()));
            end
        end
    end

    task automatic run0(input bit cp, input bit ch, input bit lp, input int n,
                        input int restart_n);
        int  stage;
        bit  done;
        loop0 = lp;
        slv_cpol = cp;
        slv_cpha = ch;
        slv_bits.delete();
        mosi_q0.delete();
        for (int i = 0; i < n; i++) begin
            exp_q0.push_back(lp ? tx_w[i] : sl_w[i]);
            if (!lp)
                for (int b = 7; b >= 0; b--) slv_bits.push_back(sl_w[i][b]);
        end
        @(negedge CLK);
        b0.cpol = cp;
        b0.cpha = ch;
        repeat (2) @(negedge CLK);
        busy0 = 0; cslow0 = 0; edges0 = 0; wd0 = 0;
        first0 = cp;
        b0.n_words = 8'(n);
        b0.din = tx_w[0];
        b0.start = 1'b1;
        @(negedge CLK);
        b0.start = 1'b0;
        stage = 1;
        if (n > 1) b0.din = tx_w[1];
        done = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            @(negedge CLK);
            if (restart_n != 0 && c == 6) begin
                b0.start = 1'b1;
                b0.n_words = 8'(restart_n);
            end else begin
                b0.start = 1'b0;
            end
            if (b0.word_done) begin
                stage++;
                if (stage < n) b0.din = tx_w[stage];
            end
            if (!b0.busy) done = 1'b1;
        end
        chk("timeout0", 32'(done), 32'(1));
        repeat (2) @(negedge CLK);
        chk("burst_len", 32'(1 + busy0), 32'(1 + DIV * (16 * n + 3)));
        chk("cs_low_cycles", 32'(cslow0), 32'(DIV * (16 * n + 2)));
        chk("sclk_edges", 32'(edges0), 32'(16 * n));
        chk("first_edge_level", 32'(first0), 32'(!cp));
        chk("word_done_cnt", 32'(wd0), 32'(n));
        chk("sclk_idle", 32'(b0.sclk), 32'(cp));
        chk("exp_q0_empty", 32'(exp_q0.size()), 32'(0));
        chk("mosi_word_cnt", 32'(mosi_q0.size()), 32'(n));
        for (int i = 0; i < n && i < mosi_q0.size(); i++)
            chk("mosi_word", 32'(mosi_q0[i]), 32'(tx_w[i]));
    endtask

    task automatic run1(input bit cp, input bit ch, input logic [11:0] d);
        bit done;
        @(negedge CLK);
        b1.cpol = cp;
        b1.cpha = ch;
        cpha1_m = ch;
        repeat (2) @(negedge CLK);
        exp_q1.push_back(d);
        wd1 = 0;
        first1 = !d[0];
        b1.n_words = 8'd1;
        b1.din = d;
        b1.start = 1'b1;
        @(negedge CLK);
        b1.start = 1'b0;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge CLK);
            if (!b1.busy) done = 1'b1;
        end
        chk("timeout1", 32'(done), 32'(1));
        repeat (2) @(negedge CLK);
        chk("word_done_cnt1", 32'(wd1), 32'(1));
        chk("first_mosi_bit1", 32'(first1), 32'(d[0]));
        chk("sclk_idle1", 32'(b1.sclk), 32'(cp));
        chk("exp_q1_empty", 32'(exp_q1.size()), 32'(0));
    endtask

    initial begin
        b0.start = 0; b0.cpol = 0; b0.cpha = 0; b0.n_words = 0; b0.din = 0;
        b1.start = 0; b1.cpol = 0; b1.cpha = 0; b1.n_words = 0; b1.din = 0;
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        chk("rst_sclk", 32'(b0.sclk), 32'(0));
        chk("rst_mosi", 32'(b0.mosi), 32'(0));
        chk("rst_cs_n", 32'(b0.cs_n), 32'(1));
        chk("rst_busy", 32'(b0.busy), 32'(0));
        chk("rst_dout", 32'(b0.dout), 32'(0));
        chk("rst_word_done", 32'(b0.word_done), 32'(0));
        chk("rst_cs_n1", 32'(b1.cs_n), 32'(1));
        chk("rst_busy1", 32'(b1.busy), 32'(0));
        RST = 1'b0;

        // mode 0 loopback, single word
        tx_w = '{8'hA5};
        run0(1'b0, 1'b0, 1'b1, 1, 0);

        // mode 3, three-word burst against a slave returning 3C
        tx_w = '{8'h11, 8'h22, 8'h33};
        sl_w = '{8'h3C, 8'h3C, 8'h3C};
        run0(1'b1, 1'b1, 1'b0, 3, 0);

        // LSB-first 12-bit mode 1 loopback
        run1(1'b0, 1'b1, 12'h801);

        // n_words = 0 is ignored
        @(negedge CLK);
        busy0 = 0; cslow0 = 0; tog0 = 0;
        b0.n_words = 8'd0;
        b0.start = 1'b1;
        @(negedge CLK);
        b0.start = 1'b0;
        repeat (10) @(negedge CLK);
        chk("nw0_busy", 32'(busy0), 32'(0));
        chk("nw0_cs_low", 32'(cslow0), 32'(0));
        chk("nw0_sclk_toggles", 32'(tog0), 32'(0));

        // start during a burst is ignored
        tx_w = '{8'h5A};
        run0(1'b0, 1'b0, 1'b1, 1, 5);

        // reset in the middle of SHIFT
        loop0 = 1'b1;
        b0.cpol = 1'b0;
        b0.cpha = 1'b0;
        slv_cpol = 1'b0;
        slv_cpha = 1'b0;
        repeat (2) @(negedge CLK);
        edges0 = 0; wd0 = 0;
        b0.n_words = 8'd1;
        b0.din = 8'hC3;
        b0.start = 1'b1;
        @(negedge CLK);
        b0.start = 1'b0;
        rdone = 1'b0;
        for (int c = 0; c < 200 && !rdone; c++) begin
            @(negedge CLK);
            if (edges0 >= 5) rdone = 1'b1;
        end
        chk("rst_reach_edge5", 32'(rdone), 32'(1));
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("midrst_cs_n", 32'(b0.cs_n), 32'(1));
        chk("midrst_sclk", 32'(b0.sclk), 32'(0));
        chk("midrst_busy", 32'(b0.busy), 32'(0));
        @(negedge CLK);
        RST = 1'b0;
        repeat (10) @(negedge CLK);
        chk("midrst_no_word_done", 32'(wd0), 32'(0));
        tx_w = '{8'h96};
        run0(1'b0, 1'b0, 1'b1, 1, 0);

        // cpol=1 idles high; mode 2 slave
        @(negedge CLK);
        b0.cpol = 1'b1;
        repeat (3) @(negedge CLK);
        chk("cpol1_idle_sclk", 32'(b0.sclk), 32'(1));
        tx_w = '{8'($urandom), 8'($urandom)};
        sl_w = '{8'($urandom), 8'($urandom)};
        run0(1'b1, 1'b0, 1'b0, 2, 0);

        // randomized bursts
        for (int k = 0; k < 8; k++) begin
            rn  = $urandom_range(3, 1);
            rcp = 1'($urandom);
            rch = 1'($urandom);
            rlp = 1'($urandom);
            tx_w.delete();
            sl_w.delete();
            for (int i = 0; i < rn; i++) begin
                tx_w.push_back(8'($urandom));
                sl_w.push_back(8'($urandom));
            end
            run0(rcp, rch, rlp, rn, 0);
        end
        for (int k = 0; k < 3; k++) begin
            rcp  = 1'($urandom);
            rch  = 1'($urandom);
            rd12 = 12'($urandom);
            run1(rcp, rch, rd12);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_master_gen.md
Name: spi_master_gen

Overview:
- Parametrised SPI master, successor to the team's fixed 8-bit mode-0 joystick interface.
- Runs entirely on the system clock CLK. SCLK is derived by a programmable divider, so no clock gating is used.
- Supports all four CPOL/CPHA modes, configurable word width, and multi-word bursts with chip select held low.
- Sits between the PmodJSTK/peripheral controller logic and the Pmod pins.

Parameters:
- DATA_W, 8: bits per word (2..32).
- CLK_DIV, 750: CLK cycles per SCLK half-period (>=2). 100 MHz / 1500 gives ~66.67 kHz.
- MSB_FIRST, 1: 1 = shift MSB first, 0 = LSB first.
- CNT_W, 8: width of n_words.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- start  in  1  begin burst. Sampled only in IDLE.
- cpol  in  1  SCLK idle level. Latched at start.
- cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge. Latched at start.
- n_words  in  CNT_W  words in the burst. Latched at start. 0 means start is ignored.
- din  in  DATA_W  transmit word. Sampled on the accepted start cycle and on each word_done cycle that has words remaining.
- miso  in  1  slave data. Already synchronised externally.
- sclk  out  1  serial clock (registered).
- mosi  out  1  master data (registered).
- cs_n  out  1  active-low chip select (registered).
- busy  out  1  high from the cycle after start is accepted until the return to IDLE.
- dout  out  DATA_W  last received word. Held until the next word_done.
- word_done  out  1  one-cycle pulse when dout is updated.

Behaviour:
- Reset: sclk=0, mosi=0, cs_n=1, busy=0, dout=0, word_done=0, state=IDLE, all counters=0, latched cpol/cpha=0. Reset aborts any transfer on the next edge; no word_done is issued.
- Tick generator:
  - div_cnt counts 0..CLK_DIV-1 while state is not IDLE, and clears in IDLE.
  - tick = (div_cnt == CLK_DIV-1).
  - Every state transition except IDLE->SETUP occurs on a tick.
- States:
  - IDLE: sclk=cpol_in (follows port), cs_n=1. If start && n_words!=0, latch the config, load the shift register with din, set words_left=n_words, then go to SETUP.
  - SETUP: cs_n=0, busy=1. If cpha=0, mosi shows the first bit. Lasts one half-period (CLK_DIV cycles), then goes to SHIFT with edge_cnt=0.
  - SHIFT: on each tick toggle sclk and increment edge_cnt (0..2*DATA_W-1).
    - Even edge_cnt = leading edge, odd = trailing edge.
    - cpha=0: sample miso on leading edges; drive the next bit on trailing edges, except after the last bit of the word.
    - cpha=1: drive the bit on leading edges; sample on trailing edges.
    - After edge 2*DATA_W-1, in the same cycle: dout <= received word, word_done=1, words_left--.
    - If words_left was >1: reload from din, reset edge_cnt, stay in SHIFT. For cpha=0, mosi shows the new first bit in that same cycle. There is no inter-word gap.
    - Otherwise go to HOLD.
  - HOLD: sclk=cpol, cs_n=0 for one half-period, then go to DONE.
  - DONE: cs_n=1, busy=1 for one half-period (minimum CS-high time), then go to IDLE with busy=0.
- Bit order follows MSB_FIRST for both tx and rx.
- dout bit mapping: the first bit received goes to dout[DATA_W-1] if MSB_FIRST, else to dout[0].
- start while busy is ignored. Changing cpol/cpha/n_words mid-burst has no effect.
- Burst length in CLK cycles from start = 1 + CLK_DIV*(2 + 2*DATA_W*n_words + 1). cs_n is low for CLK_DIV*(1 + 2*DATA_W*n_words + 1) cycles.

Decomposition:
- Package spi_pkg: state enum (IDLE, SETUP, SHIFT, HOLD, DONE) and the edge-type constants.
- Sub-module spi_clk_tick (divider counter with enable/clear, outputs tick), reused by other Pmod serial blocks.
- The shift datapath stays inline.

Test Plan:
- DATA_W=8, CLK_DIV=2, mode 0, loopback miso=mosi, n_words=1, din=8'hA5:
  - exactly 16 sclk edges, sclk idles 0.
  - one word_done, dout=8'hA5.
  - busy total 1+2*(2+16+1)=39 cycles.
- Mode 3 (cpol=1, cpha=1), slave model returning 8'h3C, n_words=3, din changed to 11/22/33 on each word_done:
  - mosi streams 11,22,33 continuously.
  - cs_n stays low throughout; 3 word_done pulses, each dout=8'h3C.
  - sclk idles 1.
- MSB_FIRST=0, DATA_W=12, mode 1, loopback, din=12'h801:
  - the first mosi bit is 1 (LSB).
  - dout=12'h801.
- n_words=0 with start=1 -> busy stays 0, cs_n stays 1, no sclk activity. A second start pulse during a burst is ignored (word count unchanged).
- RST asserted in mid-SHIFT at edge 5:
  - next cycle: cs_n=1, sclk=0, busy=0.
  - no word_done pulse.
  - a new burst after reset completes normally.
- cpol=1 with cpha=0 -> sclk goes 1 in IDLE; the first edge after SETUP is falling; dout is correct against a mode-2 slave model.
